// File: rtl/d2x4_scan_ctrl.sv
// ============================================================================
// Module   : d2x4_scan_ctrl
// Brief    : Select sequencer for the D2X4 2-to-4 decoder (auto-scan,
//            single-step, direct load, post-change blanking).
// Revision : 1.0
// ============================================================================
`default_nettype none

module d2x4_scan_ctrl #(
   parameter int unsigned DIV_W = 8,
   parameter int unsigned DIV   = 4,
   parameter int unsigned BLANK = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] mode,
   input  logic       step_req,
   output logic       step_ack,
   input  logic       load,
   input  logic [1:0] load_idx,
   output logic       A,
   output logic       B,
   output logic       valid,
   output logic       wrap
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [1:0] c_M_HOLD = 2'b00;
   localparam logic [1:0] c_M_UP   = 2'b01;
   localparam logic [1:0] c_M_DOWN = 2'b10;
   localparam logic [1:0] c_M_STEP = 2'b11;

   localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [DIV_W-1:0] c_DIV_ONE  = DIV_W'(1);
   localparam logic [3:0]       c_BLANK    = 4'(BLANK);

   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic [1:0]       r_idx;
   logic [1:0]       w_idx;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] w_div;
   logic [3:0]       r_blank;
   logic [3:0]       w_blank;
   logic [1:0]       r_mode;
   logic             r_armed;
   logic             w_armed;
   logic             r_wrap;
   logic             w_wrap;
   logic             r_ack;
   logic             w_ack;
   logic             r_valid;
   logic             w_valid;
   logic             w_changed;
   logic             w_mode_chg;

   assign w_mode_chg = (mode != r_mode);

   // State register plus all registered datapath/outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_idx   <= 2'd0;
         r_div   <= '0;
         r_blank <= 4'd0;
         r_mode  <= c_M_HOLD;
         r_armed <= 1'b1;
         r_wrap  <= 1'b0;
         r_ack   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx;
         r_div   <= w_div;
         r_blank <= w_blank;
         r_mode  <= mode;
         r_armed <= w_armed;
         r_wrap  <= w_wrap;
         r_ack   <= w_ack;
         r_valid <= w_valid;
      end
   end

   always_comb begin
      w_state_nxt = en ? S_RUN : S_IDLE;
   end

   // Load pre-empts any tick or step decided in the same cycle.
   always_comb begin
      w_idx     = r_idx;
      w_div     = '0;
      w_armed   = r_armed;
      w_wrap    = 1'b0;
      w_ack     = 1'b0;
      w_changed = 1'b0;
      if (load) begin
         w_idx     = load_idx;
         w_changed = 1'b1;
      end else if (r_state == S_RUN) begin
         case (mode)
            c_M_UP, c_M_DOWN: begin
               if (!w_mode_chg) begin
                  if (r_div == c_DIV_LAST) begin
                     w_changed = 1'b1;
                     if (mode == c_M_UP) begin
                        w_idx  = r_idx + 2'd1;
                        w_wrap = (r_idx == 2'd3);
                     end else begin
                        w_idx  = r_idx - 2'd1;
                        w_wrap = (r_idx == 2'd0);
                     end
                  end else begin
                     w_div = r_div + c_DIV_ONE;
                  end
               end
            end
            c_M_STEP: begin
               if (step_req) begin
                  if (r_armed) begin
                     w_idx     = r_idx + 2'd1;
                     w_wrap    = (r_idx == 2'd3);
                     w_ack     = 1'b1;
                     w_armed   = 1'b0;
                     w_changed = 1'b1;
                  end
               end else begin
                  w_armed = 1'b1;
               end
            end
            default: ;
         endcase
      end

      // Blanking only counts down while running; IDLE freezes it.
      w_blank = r_blank;
      if (w_changed) begin
         w_blank = c_BLANK;
      end else if ((r_state == S_RUN) && (r_blank != 4'd0)) begin
         w_blank = r_blank - 4'd1;
      end
      w_valid = (w_state_nxt == S_RUN) && (w_blank == 4'd0);
   end

   assign A        = r_idx[0];
   assign B        = r_idx[1];
   assign valid    = r_valid;
   assign wrap     = r_wrap;
   assign step_ack = r_ack;

endmodule

`default_nettype wire
